// File: rtl/uart_wb_dma.sv
// UART receive DMA: buffers rx bytes in a FIFO and packs them into 1/2/4-byte
// Wishbone writes to a circular RAM window, sharing the RAM port with the CPU.
module uart_wb_dma #(
  parameter int          DEPTH     = 16,
  parameter int          PACK      = 1,
  parameter logic [31:0] BASE_ADR  = 32'h0000_1000,
  parameter logic [31:0] LIMIT_ADR = 32'h0000_1FFF,
  parameter int          URGENT    = DEPTH-2
) (
  input  logic                     i_wb_clk,
  input  logic                     i_wb_rst,
  input  logic [7:0]               i_rx_dat,
  input  logic                     i_rx_vld,
  input  logic [31:0]              i_cpu_adr,
  input  logic [31:0]              i_cpu_dat,
  input  logic [3:0]               i_cpu_sel,
  input  logic                     i_cpu_we,
  input  logic                     i_cpu_cyc,
  output logic [31:0]              o_cpu_rdt,
  output logic                     o_cpu_ack,
  output logic [31:0]              o_mem_adr,
  output logic [31:0]              o_mem_dat,
  output logic [3:0]               o_mem_sel,
  output logic                     o_mem_we,
  output logic                     o_mem_cyc,
  input  logic [31:0]              i_mem_rdt,
  input  logic                     i_mem_ack,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_overflow,
  output logic                     o_wrap,
  output logic [31:0]              o_bytes
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [LW-1:0] DEPTH_L  = LW'(DEPTH);
  localparam logic [LW-1:0] PACK_L   = LW'(PACK);
  localparam logic [LW-1:0] URGENT_L = LW'(URGENT);
  localparam logic [32:0]   LIMIT_X  = {1'b0, LIMIT_ADR};
  localparam logic [32:0]   PACK_X   = 33'(PACK);

  typedef enum logic [1:0] {IDLE, CPU, DMA} arb_t;

  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wb_req_t;

  arb_t          state;
  logic [7:0]    fifo [DEPTH];
  logic [AW-1:0] wr_idx, rd_idx;
  logic [LW-1:0] level;
  logic [31:0]   ptr;
  logic [32:0]   next_ptr;
  logic [7:0]    hd [4];
  logic          pop, push, dma_req, urgent;
  wb_req_t       dma;

  assign pop      = (state == DMA) && i_mem_ack;
  // a full FIFO still takes a byte when the same cycle frees space
  assign push     = i_rx_vld && ((level < DEPTH_L) || pop);
  assign dma_req  = level >= PACK_L;
  assign urgent   = level >= URGENT_L;
  assign next_ptr = {1'b0, ptr} + PACK_X;
  assign o_level  = level;

  for (genvar k = 0; k < 4; k++) begin : g_hd
    assign hd[k] = fifo[rd_idx + AW'(k)];
  end

  always_comb begin
    dma.adr = {ptr[31:2], 2'b00};
    case (PACK)
      2: begin
        dma.dat = {hd[1], hd[0], hd[1], hd[0]};
        dma.sel = ptr[1] ? 4'b1100 : 4'b0011;
      end
      4: begin
        dma.dat = {hd[3], hd[2], hd[1], hd[0]};
        dma.sel = 4'b1111;
      end
      default: begin
        dma.dat = {4{hd[0]}};
        dma.sel = 4'b0001 << ptr[1:0];
      end
    endcase
  end

  always_ff @(posedge i_wb_clk)
    if (push) fifo[wr_idx] <= i_rx_dat;

  always_ff @(posedge i_wb_clk) begin
    if (i_wb_rst) begin
      state      <= IDLE;
      wr_idx     <= '0;
      rd_idx     <= '0;
      level      <= '0;
      ptr        <= BASE_ADR;
      o_overflow <= 1'b0;
      o_wrap     <= 1'b0;
      o_bytes    <= '0;
    end else begin
      o_wrap <= 1'b0;
      if (push) wr_idx <= wr_idx + AW'(1);
      if (i_rx_vld && !push) o_overflow <= 1'b1;
      level <= level + LW'(push) - (pop ? PACK_L : '0);
      if (pop) begin
        rd_idx  <= rd_idx + AW'(PACK);
        o_bytes <= o_bytes + 32'(PACK);
        if (next_ptr > LIMIT_X) begin
          ptr    <= BASE_ADR;
          o_wrap <= 1'b1;
        end else begin
          ptr <= next_ptr[31:0];
        end
      end
      // grants end on ack and always pass through IDLE, so no cycle is cut short
      case (state)
        IDLE:
          if (dma_req && (!i_cpu_cyc || urgent)) state <= DMA;
          else if (i_cpu_cyc)                    state <= CPU;
        CPU:     if (i_mem_ack) state <= IDLE;
        DMA:     if (i_mem_ack) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    o_mem_adr = dma.adr;
    o_mem_dat = dma.dat;
    o_mem_sel = dma.sel;
    o_mem_we  = 1'b0;
    o_mem_cyc = 1'b0;
    o_cpu_ack = 1'b0;
    o_cpu_rdt = i_mem_rdt;
    case (state)
      CPU: begin
        o_mem_adr = i_cpu_adr;
        o_mem_dat = i_cpu_dat;
        o_mem_sel = i_cpu_sel;
        o_mem_we  = i_cpu_we;
        o_mem_cyc = i_cpu_cyc;
        o_cpu_ack = i_mem_ack && !i_wb_rst;
      end
      DMA: begin
        o_mem_we  = 1'b1;
        o_mem_cyc = 1'b1;
      end
      default: ;
    endcase
  end
endmodule

// File: tb/tb_uart_wb_dma.sv
// Bench for uart_wb_dma: four configurations (PACK 1/2/4, DEPTH 4) against a
// byte-queue reference model and a simple acking RAM slave.
module tb_uart_wb_dma;
  typedef struct packed {
    logic [31:0] adr;
    logic [31:0] dat;
    logic [3:0]  sel;
  } wr_t;

  localparam logic [31:0] RK = 32'hA5A5_5A5A;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst [4];
  logic [7:0]  rx_dat [4];
  logic        rx_vld [4];
  logic [31:0] cpu_adr [4], cpu_dat [4];
  logic [3:0]  cpu_sel [4];
  logic        cpu_we [4], cpu_cyc [4];
  logic [31:0] cpu_rdt [4];
  logic        cpu_ack [4];
  logic [31:0] mem_adr [4], mem_dat [4];
  logic [3:0]  mem_sel [4];
  logic        mem_we [4], mem_cyc [4];
  logic [31:0] mem_rdt [4] = '{default: 32'h0};
  logic        mem_ack [4] = '{default: 1'b0};
  logic [4:0]  level [4];
  logic        overflow [4], wrap [4];
  logic [31:0] bytes [4];
  logic        ack_en [4];

  wr_t        wq [4][$];
  bit         ev [4][$];
  logic [7:0] mdl [4][$];
  int         cpu_ack_cnt [4] = '{default: 0};
  int         wrap_cnt [4] = '{default: 0};
  int         wrap_at [4] = '{default: 0};
  int         checks = 0, errors = 0;

  for (genvar g = 0; g < 4; g++) begin : g_dut
    localparam int P = (g == 1) ? 2 : (g == 2) ? 4 : 1;
    localparam int D = (g == 3) ? 4 : 16;
    localparam logic [31:0] LIM = (g == 1) ? 32'h0000_1003 : 32'h0000_1FFF;
    logic [$clog2(D):0] lv;
    uart_wb_dma #(.DEPTH(D), .PACK(P), .BASE_ADR(32'h0000_1000), .LIMIT_ADR(LIM),
                  .URGENT(D-2)) u_dut (
      .i_wb_clk(clk), .i_wb_rst(rst[g]), .i_rx_dat(rx_dat[g]), .i_rx_vld(rx_vld[g]),
      .i_cpu_adr(cpu_adr[g]), .i_cpu_dat(cpu_dat[g]), .i_cpu_sel(cpu_sel[g]),
      .i_cpu_we(cpu_we[g]), .i_cpu_cyc(cpu_cyc[g]), .o_cpu_rdt(cpu_rdt[g]),
      .o_cpu_ack(cpu_ack[g]), .o_mem_adr(mem_adr[g]), .o_mem_dat(mem_dat[g]),
      .o_mem_sel(mem_sel[g]), .o_mem_we(mem_we[g]), .o_mem_cyc(mem_cyc[g]),
      .i_mem_rdt(mem_rdt[g]), .i_mem_ack(mem_ack[g]), .o_level(lv),
      .o_overflow(overflow[g]), .o_wrap(wrap[g]), .o_bytes(bytes[g]));
    assign level[g] = 5'(lv);
  end

  // RAM slave: one-cycle ack per request when enabled; logs writes and grant order
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (rst[i]) wq[i].delete();
      if (mem_cyc[i] && !mem_ack[i] && ack_en[i]) begin
        mem_ack[i] <= 1'b1;
        mem_rdt[i] <= mem_adr[i] ^ RK;
        if (mem_we[i]) wq[i].push_back({mem_adr[i], mem_dat[i], mem_sel[i]});
        ev[i].push_back(mem_we[i]);
      end else begin
        mem_ack[i] <= 1'b0;
      end
      if (cpu_ack[i]) cpu_ack_cnt[i] <= cpu_ack_cnt[i] + 1;
      if (wrap[i]) begin
        wrap_cnt[i] <= wrap_cnt[i] + 1;
        wrap_at[i]  <= wq[i].size();
      end
    end
  end

  function automatic int pk(input int i);
    return (i == 1) ? 2 : (i == 2) ? 4 : 1;
  endfunction

  function automatic int lm(input int i);
    return (i == 1) ? 32'h1003 : 32'h1FFF;
  endfunction

  task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int i, input logic [7:0] b, input bit keep);
    rx_dat[i] = b;
    rx_vld[i] = 1'b1;
    if (keep) mdl[i].push_back(b);
    @(negedge clk);
    rx_vld[i] = 1'b0;
  endtask

  task automatic wait_wr(input int i, input int n);
    int t = 0;
    while (wq[i].size() < n && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("wait_wr%0d", i), 72'(wq[i].size() >= n), 72'd1);
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_cpu_ack(input int i);
    int t = 0;
    while (!cpu_ack[i] && t < 400) begin
      @(negedge clk);
      t++;
    end
    chk($sformatf("cpu_ack_seen%0d", i), 72'(cpu_ack[i]), 72'd1);
    chk($sformatf("cpu_rdt%0d", i), 72'(cpu_rdt[i]), 72'(cpu_adr[i] ^ RK));
    cpu_cyc[i] = 1'b0;
  endtask

  // expected writes derived from the byte stream: write j carries bytes j*p..j*p+p-1
  task automatic check_writes(input int i);
    int p, w, nw;
    logic [31:0] a;
    logic [7:0]  b [4];
    wr_t e;
    p  = pk(i);
    w  = lm(i) - 32'h1000 + 1;
    nw = mdl[i].size() / p;
    chk($sformatf("nwr%0d", i), 72'(wq[i].size()), 72'(nw));
    for (int j = 0; j < nw && j < wq[i].size(); j++) begin
      a = 32'h1000 + 32'((j * p) % w);
      for (int k = 0; k < 4; k++) b[k] = mdl[i][j*p + (k % p)];
      e.adr = {a[31:2], 2'b00};
      e.dat = {b[3], b[2], b[1], b[0]};
      e.sel = (p == 4) ? 4'b1111 : (p == 2) ? (a[1] ? 4'b1100 : 4'b0011)
                                           : (4'b0001 << a[1:0]);
      chk($sformatf("wr%0d_%0d", i, j), 72'(wq[i][j]), 72'(e));
    end
    chk($sformatf("bytes%0d", i), 72'(bytes[i]), 72'(nw * p));
    chk($sformatf("level%0d", i), 72'(level[i]), 72'(mdl[i].size() - nw * p));
  endtask

  initial begin
    int s, c0, w0, idx, nreq, t;
    for (int i = 0; i < 4; i++) begin
      rst[i] = 1'b1; rx_vld[i] = 1'b0; rx_dat[i] = 8'h0; ack_en[i] = 1'b1;
      cpu_adr[i] = '0; cpu_dat[i] = '0; cpu_sel[i] = 4'hF; cpu_we[i] = 1'b0; cpu_cyc[i] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int i = 0; i < 4; i++) rst[i] = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("rst_cyc%0d", i), 72'(mem_cyc[i]), 72'd0);
      chk($sformatf("rst_ack%0d", i), 72'(cpu_ack[i]), 72'd0);
      chk($sformatf("rst_lvl%0d", i), 72'(level[i]), 72'd0);
      chk($sformatf("rst_ovf%0d", i), 72'(overflow[i]), 72'd0);
      chk($sformatf("rst_wrap%0d", i), 72'(wrap[i]), 72'd0);
      chk($sformatf("rst_bytes%0d", i), 72'(bytes[i]), 72'd0);
    end

    // byte writes, lane follows address
    push(0, 8'h41, 1'b1);
    push(0, 8'h42, 1'b1);
    wait_wr(0, 2);
    check_writes(0);

    // word packing waits for four bytes
    push(2, 8'h11, 1'b1); push(2, 8'h22, 1'b1); push(2, 8'h33, 1'b1);
    repeat (10) @(negedge clk);
    chk("pack4_nowr", 72'(wq[2].size()), 72'd0);
    chk("pack4_lvl3", 72'(level[2]), 72'd3);
    push(2, 8'h44, 1'b1);
    wait_wr(2, 1);
    check_writes(2);

    // halfwords in a 4-byte window: wrap after the second write
    w0 = wrap_cnt[1];
    for (int k = 0; k < 6; k++) push(1, 8'hA0 + 8'(k), 1'b1);
    wait_wr(1, 3);
    check_writes(1);
    chk("wrap_cnt", 72'(wrap_cnt[1] - w0), 72'd1);
    chk("wrap_at", 72'(wrap_at[1]), 72'd2);
    chk("wrap_low", 72'(wrap[1]), 72'd0);

    // CPU requests first while the FIFO is shallow
    s = ev[0].size(); c0 = cpu_ack_cnt[0];
    cpu_adr[0] = 32'h20; cpu_we[0] = 1'b0; cpu_cyc[0] = 1'b1;
    push(0, 8'h51, 1'b1);
    push(0, 8'h52, 1'b1);
    wait_cpu_ack(0);
    wait_wr(0, 4);
    chk("arb_cpu_once", 72'(cpu_ack_cnt[0] - c0), 72'd1);
    chk("arb_order0", 72'(ev[0][s]), 72'd0);
    chk("arb_order1", 72'(ev[0][s+1]), 72'd1);
    chk("arb_order2", 72'(ev[0][s+2]), 72'd1);
    check_writes(0);

    // deep FIFO: DMA wins until the level drops below URGENT
    ack_en[0] = 1'b0;
    s = ev[0].size(); c0 = cpu_ack_cnt[0];
    for (int k = 0; k < 16; k++) push(0, 8'h60 + 8'(k), 1'b1);
    chk("urg_lvl16", 72'(level[0]), 72'd16);
    chk("urg_stuck", 72'(mem_cyc[0] && mem_we[0]), 72'd1);
    cpu_adr[0] = 32'h44; cpu_cyc[0] = 1'b1;
    repeat (2) @(negedge clk);
    ack_en[0] = 1'b1;
    wait_cpu_ack(0);
    wait_wr(0, 20);
    chk("urg_cpu_once", 72'(cpu_ack_cnt[0] - c0), 72'd1);
    idx = -1;
    for (int k = s; k < ev[0].size(); k++) if (!ev[0][k] && idx < 0) idx = k - s;
    chk("urg_cpu_slot", 72'(idx), 72'd3);
    chk("urg_ovf", 72'(overflow[0]), 72'd0);
    check_writes(0);

    // overflow on a stalled 4-deep FIFO, then push coinciding with a pop
    ack_en[3] = 1'b0;
    for (int k = 0; k < 4; k++) push(3, 8'hB0 + 8'(k), 1'b1);
    push(3, 8'hB4, 1'b0);
    push(3, 8'hB5, 1'b0);
    chk("ovf_lvl", 72'(level[3]), 72'd4);
    chk("ovf_flag", 72'(overflow[3]), 72'd1);
    chk("ovf_nowr", 72'(wq[3].size()), 72'd0);
    ack_en[3] = 1'b1;
    @(negedge clk);
    push(3, 8'hB6, 1'b1);
    wait_wr(3, 5);
    check_writes(3);
    chk("ovf_sticky", 72'(overflow[3]), 72'd1);

    // reset during an unacked DMA cycle
    ack_en[3] = 1'b0;
    push(3, 8'hC0, 1'b1);
    repeat (2) @(negedge clk);
    chk("rst_pre_cyc", 72'(mem_cyc[3]), 72'd1);
    rst[3] = 1'b1;
    mdl[3].delete();
    @(negedge clk);
    rst[3] = 1'b0;
    chk("rstm_cyc", 72'(mem_cyc[3]), 72'd0);
    chk("rstm_lvl", 72'(level[3]), 72'd0);
    chk("rstm_ovf", 72'(overflow[3]), 72'd0);
    chk("rstm_ack", 72'(cpu_ack[3]), 72'd0);
    chk("rstm_bytes", 72'(bytes[3]), 72'd0);
    ack_en[3] = 1'b1;
    push(3, 8'hC1, 1'b1);
    wait_wr(3, 1);
    check_writes(3);

    // random bytes, random CPU reads, random RAM stalls
    nreq = 0; c0 = cpu_ack_cnt[0];
    for (int n = 0; n < 800; n++) begin
      ack_en[0] = ($urandom_range(3) != 0);
      if (cpu_cyc[0] && cpu_ack[0]) begin
        chk("rnd_rdt", 72'(cpu_rdt[0]), 72'(cpu_adr[0] ^ RK));
        cpu_cyc[0] = 1'b0;
      end else if (!cpu_cyc[0] && $urandom_range(15) == 0) begin
        cpu_adr[0] = 32'($urandom_range(255)) << 2;
        cpu_cyc[0] = 1'b1;
        nreq++;
      end
      rx_vld[0] = ($urandom_range(7) == 0);
      if (rx_vld[0]) begin
        rx_dat[0] = 8'($urandom);
        mdl[0].push_back(rx_dat[0]);
      end
      @(negedge clk);
    end
    rx_vld[0] = 1'b0;
    ack_en[0] = 1'b1;
    t = 0;
    while (cpu_cyc[0] && t < 400) begin
      if (cpu_ack[0]) begin
        chk("rnd_rdt", 72'(cpu_rdt[0]), 72'(cpu_adr[0] ^ RK));
        cpu_cyc[0] = 1'b0;
      end
      @(negedge clk);
      t++;
    end
    chk("rnd_cpu_done", 72'(cpu_cyc[0]), 72'd0);
    wait_wr(0, mdl[0].size());
    chk("rnd_cpu_acks", 72'(cpu_ack_cnt[0] - c0), 72'(nreq));
    chk("rnd_ovf", 72'(overflow[0]), 72'd0);
    check_writes(0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
